// File: rtl/alu_writeback_buffer_pkg.sv
// Shared definitions for the ALU writeback buffer: flag bit positions,
// default field widths, the packet layout and the occupancy-state encodings.
package alu_writeback_buffer_pkg;

   localparam int PKG_DATA_W    = 32;
   localparam int PKG_FLAGS_W   = 6;
   localparam int PKG_PRF_TAG_W = 7;
   localparam int PKG_AL_ID_W   = 7;

   localparam int FLAG_EXECUTED   = 2;
   localparam int FLAG_EXCEPTION  = 1;
   localparam int FLAG_MISPREDICT = 0;

   typedef struct packed {
      logic [PKG_DATA_W-1:0]    result;
      logic [PKG_FLAGS_W-1:0]   flags;
      logic [PKG_PRF_TAG_W-1:0] dest_tag;
      logic                     has_dest;
      logic [PKG_AL_ID_W-1:0]   al_id;
   } wb_packet_t;

   // The encoding doubles as the 2-bit occupancy count.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_t;

endpackage

// File: rtl/alu_wb_fifo2.sv
// Generic 2-entry packet FIFO with flush; the ready output is registered so it
// never depends combinationally on the pop side.
module alu_wb_fifo2
   import alu_writeback_buffer_pkg::*;
#(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_push_valid,
   output logic         o_push_ready,
   input  logic [W-1:0] i_push_data,
   output logic         o_pop_valid,
   input  logic         i_pop_ready,
   output logic [W-1:0] o_pop_data
);

   occ_state_t r_state, w_state_next;
   logic       r_head, r_tail, w_head_next, w_tail_next;
   logic       r_ready, w_ready_next;
   logic       w_push, w_pop;
   logic [W-1:0] r_mem [2];

   assign w_push = i_push_valid & r_ready;
   assign w_pop  = (r_state != OCC_EMPTY) & i_pop_ready;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= OCC_EMPTY;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_head  <= w_head_next;
         r_tail  <= w_tail_next;
         r_ready <= w_ready_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_head_next  = r_head ^ w_pop;
      w_tail_next  = r_tail ^ w_push;
      case (r_state)
         OCC_EMPTY: if (w_push) w_state_next = OCC_ONE;
         OCC_ONE: begin
            if (w_push && !w_pop)      w_state_next = OCC_FULL;
            else if (!w_push && w_pop) w_state_next = OCC_EMPTY;
         end
         OCC_FULL:  if (w_pop) w_state_next = OCC_ONE;
         default:   w_state_next = OCC_EMPTY;
      endcase
      // Flush wins over any push or pop in the same cycle.
      if (i_flush) begin
         w_state_next = OCC_EMPTY;
         w_head_next  = 1'b0;
         w_tail_next  = 1'b0;
      end
      w_ready_next = (w_state_next != OCC_FULL);
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      end else if (w_push && !i_flush) begin
         r_mem[r_tail] <= i_push_data;
      end
   end

   assign o_push_ready = r_ready;
   assign o_pop_valid  = (r_state != OCC_EMPTY);
   assign o_pop_data   = r_mem[r_head];

endmodule

// File: rtl/alu_writeback_buffer.sv
// ALU result receiver: buffers two packets and drives writeback, bypass and
// active-list control. Define ALU_WB_PERF_CNT_EN to add saturating perf counters.
module alu_writeback_buffer
   import alu_writeback_buffer_pkg::*;
#(
   parameter int DATA_W    = PKG_DATA_W,
   parameter int FLAGS_W   = PKG_FLAGS_W,
   parameter int PRF_TAG_W = PKG_PRF_TAG_W,
   parameter int AL_ID_W   = PKG_AL_ID_W
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DATA_W-1:0]    in_result_i,
   input  logic [FLAGS_W-1:0]   in_flags_i,
   input  logic [PRF_TAG_W-1:0] in_dest_tag_i,
   input  logic                 in_has_dest_i,
   input  logic [AL_ID_W-1:0]   in_al_id_i,
   output logic                 wb_valid_o,
   input  logic                 wb_ready_i,
   output logic [DATA_W-1:0]    wb_data_o,
   output logic [PRF_TAG_W-1:0] wb_tag_o,
   output logic                 wb_we_o,
   output logic                 bypass_valid_o,
   output logic [AL_ID_W-1:0]   ctrl_al_id_o,
   output logic [FLAGS_W-1:0]   ctrl_flags_o
`ifdef ALU_WB_PERF_CNT_EN
   ,
   output logic [31:0]          perf_wb_cnt_o,
   output logic [31:0]          perf_exc_cnt_o,
   output logic [31:0]          perf_stall_cnt_o
`endif
);

   localparam int PKT_W = DATA_W + FLAGS_W + PRF_TAG_W + 1 + AL_ID_W;

   logic [PKT_W-1:0]     w_in_pkt, w_head_pkt;
   logic [DATA_W-1:0]    w_result;
   logic [FLAGS_W-1:0]   w_flags;
   logic [PRF_TAG_W-1:0] w_tag;
   logic                 w_has_dest;
   logic [AL_ID_W-1:0]   w_al_id;

   assign w_in_pkt = {in_result_i, in_flags_i, in_dest_tag_i, in_has_dest_i, in_al_id_i};

   alu_wb_fifo2 #(
      .W (PKT_W)
   ) u_fifo (
      .clk          (clk),
      .i_rst        (reset),
      .i_flush      (flush_i),
      .i_push_valid (in_valid_i),
      .o_push_ready (in_ready_o),
      .i_push_data  (w_in_pkt),
      .o_pop_valid  (wb_valid_o),
      .i_pop_ready  (wb_ready_i),
      .o_pop_data   (w_head_pkt)
   );

   assign {w_result, w_flags, w_tag, w_has_dest, w_al_id} = w_head_pkt;

   // NOPs and faulting instructions still report to control but never write.
   assign wb_we_o        = w_has_dest & w_flags[FLAG_EXECUTED] & ~w_flags[FLAG_EXCEPTION];
   assign bypass_valid_o = wb_valid_o & wb_we_o;
   assign wb_data_o      = w_result;
   assign wb_tag_o       = w_tag;
   assign ctrl_al_id_o   = w_al_id;
   assign ctrl_flags_o   = w_flags;

`ifdef ALU_WB_PERF_CNT_EN
   logic        w_pop;
   logic [2:0]  w_perf_inc;
   logic [31:0] r_perf_cnt [3];

   assign w_pop      = wb_valid_o & wb_ready_i;
   assign w_perf_inc = {in_valid_i & ~in_ready_o,
                        w_pop & w_flags[FLAG_EXCEPTION],
                        w_pop};

   // Counters ignore flush; only reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) r_perf_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_perf_inc[i] && (r_perf_cnt[i] != 32'hFFFF_FFFF))
               r_perf_cnt[i] <= r_perf_cnt[i] + 32'd1;
         end
      end
   end

   assign perf_wb_cnt_o    = r_perf_cnt[0];
   assign perf_exc_cnt_o   = r_perf_cnt[1];
   assign perf_stall_cnt_o = r_perf_cnt[2];
`endif

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Self-checking bench for alu_writeback_buffer: directed steps plus random
// traffic checked against a queue-based model of the buffer.
module tb_alu_writeback_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_result_i;
   logic [5:0]  in_flags_i;
   logic [6:0]  in_dest_tag_i;
   logic        in_has_dest_i;
   logic [6:0]  in_al_id_i;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [31:0] wb_data_o;
   logic [6:0]  wb_tag_o;
   logic        wb_we_o;
   logic        bypass_valid_o;
   logic [6:0]  ctrl_al_id_o;
   logic [5:0]  ctrl_flags_o;
`ifdef ALU_WB_PERF_CNT_EN
   logic [31:0] perf_wb_cnt_o;
   logic [31:0] perf_exc_cnt_o;
   logic [31:0] perf_stall_cnt_o;
`endif

   alu_writeback_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .flush_i        (flush_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_result_i    (in_result_i),
      .in_flags_i     (in_flags_i),
      .in_dest_tag_i  (in_dest_tag_i),
      .in_has_dest_i  (in_has_dest_i),
      .in_al_id_i     (in_al_id_i),
      .wb_valid_o     (wb_valid_o),
      .wb_ready_i     (wb_ready_i),
      .wb_data_o      (wb_data_o),
      .wb_tag_o       (wb_tag_o),
      .wb_we_o        (wb_we_o),
      .bypass_valid_o (bypass_valid_o),
      .ctrl_al_id_o   (ctrl_al_id_o),
      .ctrl_flags_o   (ctrl_flags_o)
`ifdef ALU_WB_PERF_CNT_EN
      ,
      .perf_wb_cnt_o    (perf_wb_cnt_o),
      .perf_exc_cnt_o   (perf_exc_cnt_o),
      .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [5:0]  f;
      logic [6:0]  t;
      logic        hd;
      logic [6:0]  id;
   } pkt_t;

   pkt_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_wb = 0, m_exc = 0, m_stall = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] f,
                        input logic [6:0] t, input logic hd, input logic [6:0] id);
      in_valid_i    = v;
      in_result_i   = d;
      in_flags_i    = f;
      in_dest_tag_i = t;
      in_has_dest_i = hd;
      in_al_id_i    = id;
   endtask

   task automatic check_outputs(input string tag);
      pkt_t h;
      chk({tag, ".in_ready"}, in_ready_o, q.size() < 2);
      chk({tag, ".wb_valid"}, wb_valid_o, q.size() > 0);
      if (q.size() > 0) begin
         h = q[0];
         chk({tag, ".data"},   wb_data_o, h.d);
         chk({tag, ".tag"},    wb_tag_o, h.t);
         chk({tag, ".we"},     wb_we_o, h.hd & h.f[2] & ~h.f[1]);
         chk({tag, ".bypass"}, bypass_valid_o, h.hd & h.f[2] & ~h.f[1]);
         chk({tag, ".al_id"},  ctrl_al_id_o, h.id);
         chk({tag, ".flags"},  ctrl_flags_o, h.f);
      end
   endtask

   // One clock: predict from the inputs, advance the model, compare.
   task automatic cycle(input string tag);
      bit   push, pop;
      pkt_t p;
      push = in_valid_i && (q.size() < 2);
      pop  = (q.size() > 0) && wb_ready_i;
      if (in_valid_i && q.size() == 2) m_stall++;
      if (pop) begin
         m_wb++;
         if (q[0].f[1]) m_exc++;
      end
      p = '{in_result_i, in_flags_i, in_dest_tag_i, in_has_dest_i, in_al_id_i};
      @(posedge clk);
      #1;
      if (flush_i) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(p);
      end
      $display("[%0t] %s push=%0b pop=%0b flush=%0b occ=%0d", $time, tag, push, pop, flush_i, q.size());
      check_outputs(tag);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".in_ready"}, in_ready_o, 1'b1);
      chk({tag, ".wb_valid"}, wb_valid_o, 1'b0);
      chk({tag, ".we"},       wb_we_o, 1'b0);
      chk({tag, ".bypass"},   bypass_valid_o, 1'b0);
      chk({tag, ".data"},     wb_data_o, 32'h0);
      chk({tag, ".tag"},      wb_tag_o, 7'h0);
      chk({tag, ".al_id"},    ctrl_al_id_o, 7'h0);
      chk({tag, ".flags"},    ctrl_flags_o, 6'h0);
   endtask

   initial begin
      reset      = 1'b1;
      flush_i    = 1'b0;
      wb_ready_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #12;
      check_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single packet
      wb_ready_i = 1'b1;
      drive(1, 32'h5, 6'b010100, 7'd12, 1'b1, 7'd3);
      cycle("single");
      chk("single.data_c", wb_data_o, 32'h5);
      chk("single.we_c", wb_we_o, 1'b1);
      chk("single.bypass_c", bypass_valid_o, 1'b1);
      drive(0, 0, 0, 0, 0, 0);
      cycle("single_drain");

      // Backpressure
      wb_ready_i = 1'b0;
      drive(1, 32'h11, 6'b000100, 7'd1, 1'b1, 7'd1);
      cycle("bp_a");
      drive(1, 32'h22, 6'b000100, 7'd2, 1'b1, 7'd2);
      cycle("bp_b");
      chk("bp.full_ready", in_ready_o, 1'b0);
      chk("bp.head_a", wb_data_o, 32'h11);
      drive(0, 0, 0, 0, 0, 0);
      cycle("bp_hold");
      chk("bp.hold_a", wb_data_o, 32'h11);
      wb_ready_i = 1'b1;
      cycle("bp_pop_a");
      chk("bp.head_b", wb_data_o, 32'h22);
      chk("bp.ready_back", in_ready_o, 1'b1);
      cycle("bp_pop_b");

      // Back-to-back push/pop at occupancy one
      for (int i = 1; i <= 10; i++) begin
         drive(1, i, 6'b000100, 7'(i), 1'b1, 7'(i));
         cycle("b2b");
         chk("b2b.order", wb_data_o, i);
      end
      drive(0, 0, 0, 0, 0, 0);
      cycle("b2b_drain");

      // Write suppression
      drive(1, 32'hE1, 6'b010110, 7'd5, 1'b1, 7'd9);
      cycle("exc");
      chk("exc.we_c", wb_we_o, 1'b0);
      chk("exc.flags_c", ctrl_flags_o, 6'b010110);
      drive(1, 32'hE2, 6'b000100, 7'd6, 1'b0, 7'd10);
      cycle("nop_nodest");
      chk("nop.we_c", wb_we_o, 1'b0);
      drive(1, 32'hE3, 6'b010000, 7'd7, 1'b1, 7'd11);
      cycle("not_executed");
      chk("notexec.we_c", wb_we_o, 1'b0);
      drive(0, 0, 0, 0, 0, 0);
      cycle("supp_drain");

      // Flush while full, with a packet offered on the flush cycle
      wb_ready_i = 1'b0;
      drive(1, 32'hF1, 6'b000100, 7'd1, 1'b1, 7'd1);
      cycle("fl_a");
      drive(1, 32'hF2, 6'b000100, 7'd2, 1'b1, 7'd2);
      cycle("fl_b");
      drive(1, 32'hDEAD, 6'b000100, 7'd3, 1'b1, 7'd3);
      flush_i = 1'b1;
      cycle("flush");
      flush_i = 1'b0;
      chk("flush.valid_c", wb_valid_o, 1'b0);
      chk("flush.ready_c", in_ready_o, 1'b1);
      drive(0, 0, 0, 0, 0, 0);
      wb_ready_i = 1'b1;
      cycle("flush_after");
      cycle("flush_after2");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom, 6'($urandom), 7'($urandom),
               1'($urandom), 7'($urandom));
         wb_ready_i = 1'($urandom);
         flush_i    = ($urandom_range(0, 31) == 0);
         cycle("rand");
      end
      flush_i = 1'b0;
`ifdef ALU_WB_PERF_CNT_EN
      chk("perf.wb_rand", perf_wb_cnt_o, m_wb);
      chk("perf.exc_rand", perf_exc_cnt_o, m_exc);
      chk("perf.stall_rand", perf_stall_cnt_o, m_stall);
`endif

      // Asynchronous reset while full and mid-transfer
      wb_ready_i = 1'b0;
      drive(1, 32'hA1, 6'b000100, 7'd1, 1'b1, 7'd1);
      cycle("ar_a");
      drive(1, 32'hA2, 6'b000100, 7'd2, 1'b1, 7'd2);
      cycle("ar_b");
      wb_ready_i = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("async_reset");
      q.delete();
      m_wb = 0; m_exc = 0; m_stall = 0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Three pops, one carrying an exception
      drive(1, 32'hC1, 6'b000100, 7'd1, 1'b1, 7'd1);
      cycle("pc_1");
      drive(1, 32'hC2, 6'b000110, 7'd2, 1'b1, 7'd2);
      cycle("pc_2");
      drive(1, 32'hC3, 6'b000100, 7'd3, 1'b1, 7'd3);
      cycle("pc_3");
      drive(0, 0, 0, 0, 0, 0);
      cycle("pc_drain");
`ifdef ALU_WB_PERF_CNT_EN
      chk("perf.wb3", perf_wb_cnt_o, 32'd3);
      chk("perf.exc1", perf_exc_cnt_o, 32'd1);
      chk("perf.stall_model", perf_stall_cnt_o, m_stall);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
